vram_arbiter: RTL
=================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, VRAM address width.
REQ-002 Parameter DATA_W, default 6, VRAM character code width.
REQ-003 Parameter DEPTH, default 960, character cells to clear (40x24).
REQ-004 Parameter CLEAR_CHAR, default 6'h20, code written by a clear sweep.
REQ-005 clk25  input  1  system clock, 25 MHz; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 disp_req  input  1  display fetch request, one-cycle pulse per fetch.
REQ-008 disp_addr  input  ADDR_W  display fetch address, valid with disp_req.
REQ-009 disp_valid  output  1  display read data valid.
REQ-010 disp_rdata  output  DATA_W  display read data.
REQ-011 term_wr_req  input  1  terminal write request, level, held until term_ack.
REQ-012 term_addr  input  ADDR_W  terminal write address, stable while term_wr_req high.
REQ-013 term_wdata  input  DATA_W  terminal write data, stable while term_wr_req high.
REQ-014 term_ack  output  1  one-cycle pulse: terminal write issued.
REQ-015 cls_start  input  1  clear-screen start pulse.
REQ-016 cls_busy  output  1  clear sweep in progress.
REQ-017 ram_addr  output  ADDR_W  VRAM address, registered.
REQ-018 ram_we  output  1  VRAM write enable, registered.
REQ-019 ram_wdata  output  DATA_W  VRAM write data, registered.
REQ-020 ram_rdata  input  DATA_W  VRAM read data, one cycle after ram_addr (synchronous RAM).

Function
REQ-021 Each cycle N the arbiter SHALL grant at most one of DISP, CLEAR, TERM, with fixed priority DISP > CLEAR > TERM.
REQ-022 A grant in cycle N SHALL drive ram_addr/ram_we/ram_wdata in cycle N+1; with no grant, ram_we SHALL be 0 and ram_addr SHALL hold its previous value.
REQ-023 DISP grant: ram_addr=disp_addr, ram_we=0; disp_valid SHALL be 1 in cycle N+2 with disp_rdata=ram_rdata; fixed latency 2, never stalled.
REQ-024 disp_valid SHALL be 0 in all other cycles, and disp_rdata SHALL be don't-care when disp_valid=0.
REQ-025 TERM grant requires term_wr_req=1, cls_busy=0, no DISP request, and no TERM grant in cycle N-1; ram_we=1, ram_addr=term_addr, ram_wdata=term_wdata in N+1; term_ack=1 in N+1 only.
REQ-026 The one-cycle TERM turnaround of REQ-025 SHALL ensure that a request held high through its ack is written exactly once.
REQ-027 Clear FSM states: C_IDLE, C_RUN. cls_start in C_IDLE -> C_RUN with clear counter=0; cls_busy=1 in the cycle after cls_start and SHALL remain 1 while in C_RUN.
REQ-028 C_RUN: each cycle without a DISP request is a CLEAR grant: ram_we=1, ram_addr=counter, ram_wdata=CLEAR_CHAR; counter increments by 1 after each issued write.
REQ-029 After the write at address DEPTH-1 is granted, the FSM SHALL return to C_IDLE; cls_busy SHALL be 0 from the cycle in which that write appears on the RAM port.
REQ-030 cls_start while in C_RUN SHALL restart the counter at 0; no address SHALL be skipped.
REQ-031 While cls_busy=1, term_wr_req SHALL NOT be acknowledged; a pending request SHALL be granted at the first eligible cycle after cls_busy falls.
REQ-032 Counter width SHALL be ADDR_W; no address >= DEPTH SHALL be written by a sweep.

Reset
REQ-033 While rst=1, on each clock edge: ram_we=0, ram_addr=0, ram_wdata=0, disp_valid=0, term_ack=0, cls_busy=0, FSM=C_IDLE, counter=0, turnaround flag clear.
REQ-034 rst asserted mid-sweep or mid-access SHALL abort it; no write SHALL be issued after the cycle in which rst is sampled high, and any pending disp_valid SHALL be dropped.

Verification
REQ-035 disp_req=1, disp_addr=10'h005 in cycle 0; RAM model holds 6'h12 at 5 -> ram_addr=5, ram_we=0 in cycle 1; disp_valid=1, disp_rdata=6'h12 in cycle 2.
REQ-036 term_wr_req held high with addr 10'h010, data 6'h01, no display traffic -> exactly one write to 10'h010, term_ack pulses once; the request is dropped after the ack.
REQ-037 disp_req and term_wr_req both 1 in the same cycle -> display read issued first; term write issued the next cycle.
REQ-038 cls_start with no other traffic -> 960 consecutive writes of 6'h20 to addresses 0..959, cls_busy high 960 cycles, no write to address 960.
REQ-039 Sweep with disp_req every 2nd cycle and term_wr_req pending -> every display read returns with latency 2; term_ack only after cls_busy=0; all 960 cells cleared.
REQ-040 rst pulsed at counter=300 -> ram_we=0 from the next cycle, cls_busy=0; a new cls_start restarts the sweep at address 0.

Source files
------------

// File: rtl/vram_arbiter.sv
// Shares one synchronous VRAM port between display reads, terminal writes and a clear sweep.
// Priority DISP > CLEAR > TERM; display data returns exactly 2 cycles after disp_req.
module vram_arbiter #(
  parameter int                ADDR_W     = 10,
  parameter int                DATA_W     = 6,
  parameter int                DEPTH      = 960,
  parameter logic [DATA_W-1:0] CLEAR_CHAR = 6'h20
) (
  input  logic              clk25,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              term_wr_req,
  input  logic [ADDR_W-1:0] term_addr,
  input  logic [DATA_W-1:0] term_wdata,
  output logic              term_ack,
  input  logic              cls_start,
  output logic              cls_busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [0:0] C_IDLE = 1'b0;
  localparam logic [0:0] C_RUN  = 1'b1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              turn_q;
  logic              ack_q;
  logic              rd_pend_q;
  logic              rd_vld_q;

  logic disp_gnt, clr_gnt, term_gnt;

  always_comb begin
    disp_gnt = disp_req;
    clr_gnt  = !disp_req && (state_q == C_RUN);
    // turn_q blocks the cycle in which the requester is still seeing its ack
    term_gnt = !disp_req && (state_q == C_IDLE) && term_wr_req && !turn_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    wdata_d = wdata_q;
    if (disp_gnt) begin
      addr_d = disp_addr;
    end else if (clr_gnt) begin
      addr_d  = cnt_q;
      we_d    = 1'b1;
      wdata_d = CLEAR_CHAR;
      if (cnt_q == LAST_ADDR) begin
        state_d = C_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (term_gnt) begin
      addr_d  = term_addr;
      we_d    = 1'b1;
      wdata_d = term_wdata;
    end
    // A restart overrides the counter advance; the write granted this cycle still issues
    if (cls_start) begin
      state_d = C_RUN;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      state_q   <= C_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      turn_q    <= 1'b0;
      ack_q     <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      turn_q    <= term_gnt;
      ack_q     <= term_gnt;
      rd_pend_q <= disp_gnt;
      rd_vld_q  <= rd_pend_q;
    end
  end

  assign ram_addr   = addr_q;
  assign ram_we     = we_q;
  assign ram_wdata  = wdata_q;
  assign term_ack   = ack_q;
  assign cls_busy   = (state_q == C_RUN);
  assign disp_valid = rd_vld_q;
  assign disp_rdata = ram_rdata;

endmodule
